// File: rtl/cnn_seq_if.sv
// cnn_seq_if: load, stage handshake and result stream signals of cnn_seq_ctrl
interface cnn_seq_if #(
    parameter int DW    = 8,
    parameter int N_OUT = 1,
    parameter int DAW   = 6,
    parameter int WAW   = 6
);
    logic                mode;
    logic [DW-1:0]       din;
    logic                ram_en;
    logic                calc_en;
    logic                data_wen;
    logic [DAW-1:0]      data_waddr;
    logic                weight_wen;
    logic [WAW-1:0]      weight_waddr;
    logic                conv_en;
    logic                pool_en;
    logic                connect_en;
    logic                conv_fin;
    logic                pool_fin;
    logic                connect_fin;
    logic [N_OUT*DW-1:0] res_data;
    logic [DW-1:0]       dout;
    logic                out_data_flag;
    logic                busy;
    logic                err;
    modport master (
        output mode, din, ram_en, calc_en, conv_fin, pool_fin, connect_fin, res_data,
        input  data_wen, data_waddr, weight_wen, weight_waddr, conv_en, pool_en, connect_en,
               dout, out_data_flag, busy, err
    );
    modport slave (
        input  mode, din, ram_en, calc_en, conv_fin, pool_fin, connect_fin, res_data,
        output data_wen, data_waddr, weight_wen, weight_waddr, conv_en, pool_en, connect_en,
               dout, out_data_flag, busy, err
    );
endinterface

// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl: byte-serial RAM load tracking and conv/pool/FC sequencing with watchdog and result streaming
module cnn_seq_ctrl #(
    parameter int DW           = 8,
    parameter int DATA_DEPTH   = 64,
    parameter int WEIGHT_DEPTH = 54,
    parameter int N_OUT        = 1,
    parameter int MODE_DATA    = 0,
    parameter int MODE_WEIGHT  = 1,
    parameter int TIMEOUT      = 1024
) (
    input logic      clk,
    input logic      rst_n,
    cnn_seq_if.slave bus
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int WAW = $clog2(WEIGHT_DEPTH);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int OW  = N_OUT > 1 ? $clog2(N_OUT) : 1;
    typedef enum logic [2:0] {S_IDLE, S_CONV, S_POOL, S_FC, S_OUT} state_t;
    state_t              state_q, state_d;
    logic                mode_q;
    logic [DAW-1:0]      daddr_q, daddr_d;
    logic [WAW-1:0]      waddr_q, waddr_d;
    logic                dld_q, dld_d, wld_q, wld_d;
    logic [TW-1:0]       wd_q, wd_d;
    logic [OW-1:0]       ocnt_q, ocnt_d;
    logic [N_OUT*DW-1:0] sh_q, sh_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic                flag_q, flag_d, conv_q, conv_d, pool_q, pool_d, conn_q, conn_d, err_q, err_d;
    logic                busy, dwen, wwen, mode_chg, fin, dlast, wlast;
    logic                unused_din;
    assign busy     = state_q != S_IDLE;
    assign mode_chg = bus.mode != mode_q;
    assign dwen     = rst_n & bus.ram_en & (bus.mode == 1'(MODE_DATA)) & ~busy;
    assign wwen     = rst_n & bus.ram_en & (bus.mode == 1'(MODE_WEIGHT)) & ~busy;
    assign dlast    = daddr_q == DAW'(DATA_DEPTH - 1);
    assign wlast    = waddr_q == WAW'(WEIGHT_DEPTH - 1);
    assign fin      = state_q == S_CONV ? bus.conv_fin : state_q == S_POOL ? bus.pool_fin : bus.connect_fin;
    // din goes straight to the RAMs outside this block
    assign unused_din = ^bus.din;
    always_comb begin
        daddr_d = mode_chg ? '0 : dwen ? (dlast ? '0 : daddr_q + DAW'(1)) : daddr_q;
        waddr_d = mode_chg ? '0 : wwen ? (wlast ? '0 : waddr_q + WAW'(1)) : waddr_q;
        dld_d   = dwen && dlast ? 1'b1 : dwen && daddr_q == '0 ? 1'b0 : dld_q;
        wld_d   = wwen && wlast ? 1'b1 : wwen && waddr_q == '0 ? 1'b0 : wld_q;
        state_d = state_q;
        wd_d    = wd_q + TW'(1);
        ocnt_d  = ocnt_q;
        sh_d    = sh_q;
        dout_d  = '0;
        flag_d  = 1'b0;
        conv_d  = 1'b0;
        pool_d  = 1'b0;
        conn_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (bus.calc_en && !bus.ram_en && dld_q && wld_q) begin
                state_d = S_CONV;
                conv_d  = 1'b1;
                err_d   = 1'b0;
                wd_d    = '0;
            end
            S_CONV, S_POOL, S_FC: if (fin) begin
                state_d = state_q == S_CONV ? S_POOL : state_q == S_POOL ? S_FC : S_OUT;
                pool_d  = state_q == S_CONV;
                conn_d  = state_q == S_POOL;
                wd_d    = '0;
                if (state_q == S_FC) begin
                    sh_d   = bus.res_data >> DW;
                    dout_d = bus.res_data[DW-1:0];
                    flag_d = 1'b1;
                    ocnt_d = OW'(N_OUT - 1);
                end
            end else if (wd_q == TW'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
            S_OUT: if (ocnt_q == '0) state_d = S_IDLE;
            else begin
                dout_d = sh_q[DW-1:0];
                sh_d   = sh_q >> DW;
                flag_d = 1'b1;
                ocnt_d = ocnt_q - OW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            daddr_q <= '0;
            waddr_q <= '0;
            dld_q   <= 1'b0;
            wld_q   <= 1'b0;
            wd_q    <= '0;
            ocnt_q  <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            flag_q  <= 1'b0;
            conv_q  <= 1'b0;
            pool_q  <= 1'b0;
            conn_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= bus.mode;
            daddr_q <= daddr_d;
            waddr_q <= waddr_d;
            dld_q   <= dld_d;
            wld_q   <= wld_d;
            wd_q    <= wd_d;
            ocnt_q  <= ocnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            flag_q  <= flag_d;
            conv_q  <= conv_d;
            pool_q  <= pool_d;
            conn_q  <= conn_d;
            err_q   <= err_d;
        end
    end
    assign bus.data_wen      = dwen;
    assign bus.data_waddr    = daddr_q;
    assign bus.weight_wen    = wwen;
    assign bus.weight_waddr  = waddr_q;
    assign bus.conv_en       = conv_q;
    assign bus.pool_en       = pool_q;
    assign bus.connect_en    = conn_q;
    assign bus.dout          = dout_q;
    assign bus.out_data_flag = flag_q;
    assign bus.busy          = busy;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl: randomized scoreboard bench for cnn_seq_ctrl
module tb_cnn_seq_ctrl;
    localparam int DD = 64, WD = 54, NO = 4, TO = 16;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    cnn_seq_if #(.DW(8), .N_OUT(NO), .DAW(6), .WAW(6)) bus();
    cnn_seq_ctrl #(.DW(8), .DATA_DEPTH(DD), .WEIGHT_DEPTH(WD), .N_OUT(NO), .MODE_DATA(0),
                   .MODE_WEIGHT(1), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0, errors = 0;
    int dq[$], wq[$];
    logic [7:0] oq[$];
    int d_cnt = 0, w_cnt = 0;
    bit d_ld = 0, w_ld = 0, cur_mode = 0;
    int n_conv = 0, n_pool = 0, n_conn = 0, e_conv = 0, e_pool = 0, e_conn = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask
    task automatic fail_extra(input string n);
        checks++;
        errors++;
        $display("FAIL %s got=unexpected want=none", n);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) if (rst_n) begin
        if (bus.out_data_flag) begin
            if (oq.size() == 0) fail_extra("extra_out");
            else chk("dout", bus.dout, oq.pop_front());
        end else chk("dout_idle", bus.dout, 0);
        if (bus.data_wen) begin
            if (dq.size() == 0) fail_extra("extra_data_wen");
            else chk("data_waddr", bus.data_waddr, dq.pop_front());
        end
        if (bus.weight_wen) begin
            if (wq.size() == 0) fail_extra("extra_weight_wen");
            else chk("weight_waddr", bus.weight_waddr, wq.pop_front());
        end
        n_conv += int'(bus.conv_en);
        n_pool += int'(bus.pool_en);
        n_conn += int'(bus.connect_en);
    end

    task automatic push_wr();
        if (cur_mode == 0) begin
            dq.push_back(d_cnt);
            if (d_cnt == 0) d_ld = 0;
            if (d_cnt == DD - 1) begin d_ld = 1; d_cnt = 0; end else d_cnt++;
        end else begin
            wq.push_back(w_cnt);
            if (w_cnt == 0) w_ld = 0;
            if (w_cnt == WD - 1) begin w_ld = 1; w_cnt = 0; end else w_cnt++;
        end
    endtask
    task automatic wr(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ram_en = 1;
            bus.din = 8'($urandom);
            push_wr();
            tick();
        end
        bus.ram_en = 0;
    endtask
    task automatic set_mode(input bit m);
        if (m != cur_mode) begin d_cnt = 0; w_cnt = 0; end
        cur_mode = m;
        bus.mode = m;
        tick();
    endtask
    task automatic set_fin(input int i, input logic v);
        if (i == 0) bus.conv_fin = v;
        else if (i == 1) bus.pool_fin = v;
        else bus.connect_fin = v;
    endtask
    task automatic stage(input int i, input int d, input bit bw);
        for (int k = 1; k < d; k++) begin
            if (bw) begin
                bus.ram_en = 1;
                #1;
                chk("busy_wen", {bus.data_wen, bus.weight_wen}, 0);
            end
            tick();
            bus.ram_en = 0;
        end
        set_fin(i, 1);
        tick();
        set_fin(i, 0);
    endtask

    task automatic run_calc(input logic [31:0] res, input int d0, input int d1, input int d2,
                            input int sel, input bit with_ram);
        bit ok, bad;
        int k;
        ok = d_ld && w_ld && !with_ram;
        bus.calc_en = 1;
        bus.res_data = res;
        if (with_ram) begin bus.ram_en = 1; push_wr(); end
        tick();
        bus.calc_en = 0;
        bus.ram_en = 0;
        chk("conv_en", bus.conv_en, ok);
        chk("busy_start", bus.busy, ok);
        if (!ok) begin
            repeat (2) tick();
            chk("busy_ignored", bus.busy, 0);
            return;
        end
        e_conv++;
        chk("err_clear", bus.err, 0);
        stage(0, d0, sel == 1);
        if (sel == 1) begin
            chk("busy_daddr", bus.data_waddr, d_cnt);
            chk("busy_waddr", bus.weight_waddr, w_cnt);
        end
        chk("pool_en", bus.pool_en, 1);
        e_pool++;
        if (sel == 2) begin
            bad = 0;
            for (k = 1; k <= 40; k++) begin
                tick();
                if (bus.connect_en) bad = 1;
                if (!bus.busy) break;
            end
            chk("wd_cycles", k, TO);
            chk("wd_err", bus.err, 1);
            chk("wd_no_connect", bad, 0);
            return;
        end
        stage(1, d1, 0);
        chk("connect_en", bus.connect_en, 1);
        e_conn++;
        if (sel == 3) begin
            @(negedge clk);
            #1;
            rst_n = 0;
            #1;
            chk("rst_fc_outs", {bus.data_wen, bus.weight_wen, bus.data_waddr, bus.weight_waddr,
                bus.conv_en, bus.pool_en, bus.connect_en, bus.dout, bus.out_data_flag, bus.busy, bus.err}, 0);
            d_cnt = 0; w_cnt = 0; d_ld = 0; w_ld = 0;
            tick();
            tick();
            rst_n = 1;
            tick();
            return;
        end
        for (int j = 0; j < NO; j++) oq.push_back(res[8*j +: 8]);
        stage(2, d2, 0);
        bus.res_data = $urandom;
        repeat (NO - 1) tick();
        chk("busy_out", bus.busy, 1);
        tick();
        chk("busy_end", bus.busy, 0);
        chk("out_drained", oq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        bus.mode = 0; bus.din = 0; bus.ram_en = 0; bus.calc_en = 0;
        bus.conv_fin = 0; bus.pool_fin = 0; bus.connect_fin = 0; bus.res_data = 0;
        repeat (3) tick();
        chk("rst_outs", {bus.data_wen, bus.weight_wen, bus.data_waddr, bus.weight_waddr, bus.conv_en,
            bus.pool_en, bus.connect_en, bus.dout, bus.out_data_flag, bus.busy, bus.err}, 0);
        rst_n = 1;
        tick();
        run_calc($urandom, 1, 1, 1, 0, 0);
        set_mode(1); wr(WD);
        set_mode(0); wr(DD - 1);
        run_calc($urandom, 1, 1, 1, 0, 0);
        wr(1);
        run_calc(32'h44332211, 3, 3, 3, 0, 0);
        bus.conv_fin = 1; bus.pool_fin = 1; bus.connect_fin = 1;
        repeat (3) tick();
        bus.conv_fin = 0; bus.pool_fin = 0; bus.connect_fin = 0;
        chk("fins_idle", {bus.busy, bus.conv_en, bus.pool_en, bus.connect_en, bus.out_data_flag}, 0);
        run_calc($urandom, 2, 2, 2, 0, 1);
        wr(DD - 1);
        run_calc($urandom, 5, 2, 2, 1, 0);
        wr(DD);
        run_calc($urandom, 2, 1, 1, 2, 0);
        chk("err_sticky", bus.err, 1);
        run_calc($urandom, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            run_calc($urandom, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6), 0, 0);
        wr(10);
        set_mode(1);
        chk("toggle_daddr", bus.data_waddr, 0);
        chk("toggle_waddr", bus.weight_waddr, 0);
        set_mode(0);
        wr(DD);
        run_calc($urandom, 2, 3, 1, 0, 0);
        run_calc($urandom, 2, 2, 2, 3, 0);
        run_calc($urandom, 1, 1, 1, 0, 0);
        set_mode(0); wr(DD);
        run_calc($urandom, 1, 1, 1, 0, 0);
        set_mode(1); wr(WD);
        run_calc($urandom, 2, 2, 2, 0, 0);
        chk("conv_pulses", n_conv, e_conv);
        chk("pool_pulses", n_pool, e_pool);
        chk("connect_pulses", n_conn, e_conn);
        chk("wr_drained", dq.size() + wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cnn_seq_ctrl.md
# cnn_seq_ctrl

Parametrised load-and-sequence controller for the CNN accelerator. It combines byte-serial loading of the data and weight RAMs with sequencing of the conv → pool → fully-connected stages, then streams the result bytes out. Relative to the fixed single-output flow, it adds:
- configurable RAM depths and result count;
- load-complete tracking, with compute blocked until both RAMs are full;
- a per-stage watchdog with a sticky error flag;
- multi-byte output streaming.

## Interface
Parameters:
- DW, 8, byte/data width
- DATA_DEPTH, 64, data RAM words (IMG_W*IMG_H*IN_CH)
- WEIGHT_DEPTH, 54, weight RAM words (conv + FC weights)
- N_OUT, 1, result words streamed per computation (≥1)
- MODE_DATA, 0, `mode` value that selects the data RAM
- MODE_WEIGHT, 1, `mode` value that selects the weight RAM
- TIMEOUT, 1024, max cycles to wait for any stage `*_fin` (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  load target select
- din  in  DW  load byte (passed to the RAMs externally; not registered here)
- ram_en  in  1  write strobe, one word per cycle high
- calc_en  in  1  start computation (level sampled)
- data_wen  out  1  data RAM write enable
- data_waddr  out  clog2(DATA_DEPTH)  data RAM write address
- weight_wen  out  1  weight RAM write enable
- weight_waddr  out  clog2(WEIGHT_DEPTH)  weight RAM write address
- conv_en / pool_en / connect_en  out  1 each  one-cycle stage start pulses
- conv_fin / pool_fin / connect_fin  in  1 each  stage done (only sampled in the matching state)
- res_data  in  N_OUT*DW  FC results, word 0 in bits [DW-1:0]
- dout  out  DW  streamed result word
- out_data_flag  out  1  `dout` valid
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky watchdog error

## Operation
- Load path (combinational enables, registered address counters):
  - `data_wen = ram_en & (mode==MODE_DATA) & ~busy`; `weight_wen` likewise for MODE_WEIGHT.
  - Each counter advances by 1 after every enabled write. At depth-1 it wraps to 0 and sets that RAM's loaded bit.
  - A write at address 0 clears the loaded bit, so a new pass invalidates it until completion.
  - A change of `mode` (registered compare) resets both counters to 0. This does not clear the loaded bits.
  - `ram_en` while busy is ignored: no write, no counter change.
- FSM states: IDLE, CONV, POOL, FC, OUT.
  - IDLE → CONV when `calc_en=1`, `ram_en=0`, and both loaded bits are set. `conv_en` pulses on the entry cycle and `err` clears.
  - `calc_en` with either RAM not loaded, or with `ram_en` high in the same cycle, is ignored (load has priority).
  - CONV → POOL on `conv_fin` (`pool_en` pulses on entry).
  - POOL → FC on `pool_fin` (`connect_en` pulses on entry).
  - FC → OUT on `connect_fin`. `res_data` is captured into a shift register on that edge.
  - OUT: emits one word per cycle for N_OUT cycles, word 0 first, then → IDLE.
- Watchdog:
  - A counter resets on entry to CONV, POOL and FC.
  - If it reaches TIMEOUT-1 without the stage's fin → IDLE, `err`=1. No output is produced.
- Loaded bits persist after a computation, so repeated `calc_en` reuses the RAM contents.
- `dout` is 0 whenever `out_data_flag`=0.

## Timing
- Reset (asynchronous, any state): all outputs 0, both counters 0, loaded bits 0, state IDLE. No stage pulse occurs after reset release until a new valid `calc_en`.
- Stage start: `calc_en` sampled at edge T → `conv_en`=1 during cycle T+1 only.
- Stage handoff: `conv_fin` sampled at edge T → `pool_en` during cycle T+1. `pool_fin` → `connect_en` the same way.
  - A fin may arrive as early as the cycle after the start pulse.
  - Fins are ignored outside their own state.
- Output: `connect_fin` at edge T → `out_data_flag`=1 during cycles T+1 … T+N_OUT, with `dout` = word k in cycle T+1+k.
  - `busy` drops in cycle T+N_OUT+1.
  - Back-to-back `calc_en` is accepted from that cycle onward.
- Minimum end-to-end latency, from `calc_en` edge to first `out_data_flag`: 4 cycles.
- Watchdog: entry at cycle E with no fin → `busy`=0 and `err`=1 from cycle E+TIMEOUT.
- Write addresses update the cycle after each write. `waddr` presented with `wen` is the pre-increment value.

## Test plan
- Load 64 data bytes (mode=0), then 54 weight bytes (mode=1); pulse `calc_en`:
  - waddr sequences run 0..63 and 0..53, with `wen` high each write;
  - `conv_en` appears 1 cycle after `calc_en`.
- Full flow with N_OUT=4, `res_data`=0x44332211, fins returned after 3 cycles each → `dout` is 0x11, 0x22, 0x33, 0x44 on 4 consecutive flagged cycles, then `busy`=0.
- `calc_en` after only 63 data bytes → no `conv_en`, `busy` stays 0. One more byte then `calc_en` → flow starts.
- Withhold `pool_fin` with TIMEOUT=16 → `err`=1 and `busy`=0 exactly 16 cycles after POOL entry, no `connect_en`. The next valid `calc_en` clears `err`.
- `ram_en` pulses during CONV → `data_wen`/`weight_wen` stay 0 and addresses are unchanged. Toggling `mode` mid-load → both addresses return to 0.
- Assert `rst_n`=0 while in FC → all outputs 0 immediately. After release, `calc_en` is ignored until both RAMs are fully reloaded.
